// File: rtl/flash_dma_pkg.sv
// Shared types and constants for the flash-to-buffer transfer engine.
package flash_dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } state_e;

  localparam logic [15:0] OFF_START = 16'd0;
  localparam logic [15:0] OFF_ACK   = 16'd1;
  localparam logic [15:0] OFF_ABORT = 16'd2;

  localparam int unsigned STAT_ABORTED = 15;
  localparam int unsigned STAT_IRQ     = 14;
  localparam int unsigned STAT_BUSY    = 13;
  localparam int unsigned STAT_COUNT_W = 9;

endpackage

// File: rtl/dp_buffer.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Same-address read and write in one cycle returns the old word.
module dp_buffer #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 8
) (
  input  logic              clock,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rd_data_q;

  always_ff @(posedge clock) begin
    if (we) begin
      mem_q[wr_addr] <= wr_data;
    end
    rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/flash_dma_buffer.sv
// CPU-armed transfer engine: pulls N flash words into an internal buffer,
// raises a level interrupt on completion, held until acknowledged.
module flash_dma_buffer
  import flash_dma_pkg::*;
#(
  parameter int unsigned DATA_W  = 16,
  parameter int unsigned ADDR_W  = 8,
  parameter logic [15:0] IO_BASE = 16'h5000
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              write_io,
  input  logic [15:0]       io_addr,
  input  logic [15:0]       io_wdata,
  input  logic [DATA_W-1:0] flash_data,
  input  logic              flash_valid,
  output logic              get_data,
  output logic              irq,
  output logic              busy,
  output logic [15:0]       status,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  localparam int unsigned CNT_W = ADDR_W + 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  len_q, len_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic              aborted_q, aborted_d;
  logic              get_data_q, irq_q, busy_q;

  logic start_hit_c, ack_hit_c, abort_hit_c, accept_c;
  logic unused_wdata;

  // I/O register decode
  assign start_hit_c = write_io && (io_addr == 16'(IO_BASE + OFF_START));
  assign ack_hit_c   = write_io && (io_addr == 16'(IO_BASE + OFF_ACK));
  assign abort_hit_c = write_io && (io_addr == 16'(IO_BASE + OFF_ABORT));

  // get_data_q mirrors the FETCH state, so it gates word acceptance
  assign accept_c     = get_data_q && flash_valid;
  assign unused_wdata = ^io_wdata[15:ADDR_W];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      len_q      <= '0;
      count_q    <= '0;
      wr_addr_q  <= '0;
      aborted_q  <= 1'b0;
      get_data_q <= 1'b0;
      irq_q      <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      len_q      <= len_d;
      count_q    <= count_d;
      wr_addr_q  <= wr_addr_d;
      aborted_q  <= aborted_d;
      get_data_q <= (state_d == FETCH);
      busy_q     <= (state_d == FETCH);
      irq_q      <= (state_d == DONE);
    end
  end

  always_comb begin
    state_d   = state_q;
    len_d     = len_q;
    count_d   = count_q;
    wr_addr_d = wr_addr_q;
    aborted_d = aborted_q;
    unique case (state_q)
      IDLE: begin
        if (start_hit_c) begin
          len_d     = CNT_W'(io_wdata[ADDR_W-1:0]) + CNT_W'(1);
          count_d   = '0;
          wr_addr_d = '0;
          aborted_d = 1'b0;
          state_d   = FETCH;
        end
      end
      FETCH: begin
        if (accept_c) begin
          wr_addr_d = wr_addr_q + ADDR_W'(1);
          count_d   = count_q + CNT_W'(1);
          if (count_d == len_q) begin
            state_d = DONE;
          end
        end
        // abort wins over a completing word in the same cycle
        if (abort_hit_c) begin
          aborted_d = 1'b1;
          state_d   = IDLE;
        end
      end
      DONE: begin
        if (ack_hit_c) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    status                      = '0;
    status[STAT_ABORTED]        = aborted_q;
    status[STAT_IRQ]            = irq_q;
    status[STAT_BUSY]           = busy_q;
    status[STAT_COUNT_W-1:0]    = STAT_COUNT_W'(count_q);
  end

  assign get_data = get_data_q;
  assign irq      = irq_q;
  assign busy     = busy_q;

  dp_buffer #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_buf (
    .clock   (clock),
    .we      (accept_c),
    .wr_addr (wr_addr_q),
    .wr_data (flash_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

endmodule

// File: tb/tb_flash_dma_buffer.sv
// Randomised bench for flash_dma_buffer against a transaction-level model.
module tb_flash_dma_buffer;

  localparam logic [15:0] A_START = 16'h5000;
  localparam logic [15:0] A_ACK   = 16'h5001;
  localparam logic [15:0] A_ABORT = 16'h5002;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        write_io = 1'b0;
  logic [15:0] io_addr = '0;
  logic [15:0] io_wdata = '0;
  logic [15:0] flash_data = '0;
  logic        flash_valid = 1'b0;
  logic        get_data, irq, busy;
  logic [15:0] status;
  logic [7:0]  rd_addr = '0;
  logic [15:0] rd_data;

  int n_pass = 0;
  int n_total = 0;

  // model: mode 0 = idle, 1 = fetching, 2 = waiting for ack
  logic [15:0] m_mem [256];
  int          m_mode = 0;
  int          m_len = 0;
  int          m_count = 0;
  int          m_wr = 0;
  logic        m_aborted = 1'b0;

  flash_dma_buffer dut (
    .clock       (clock),
    .reset       (reset),
    .write_io    (write_io),
    .io_addr     (io_addr),
    .io_wdata    (io_wdata),
    .flash_data  (flash_data),
    .flash_valid (flash_valid),
    .get_data    (get_data),
    .irq         (irq),
    .busy        (busy),
    .status      (status),
    .rd_addr     (rd_addr),
    .rd_data     (rd_data)
  );

  always #5 clock = ~clock;

  function automatic logic [18:0] m_outs();
    logic [15:0] st;
    st = {m_aborted, 1'(m_mode == 2), 1'(m_mode == 1), 4'b0, 9'(m_count)};
    return {1'(m_mode == 1), 1'(m_mode == 1), 1'(m_mode == 2), st};
  endfunction

  task automatic model_reset();
    m_mode = 0; m_len = 0; m_count = 0; m_wr = 0; m_aborted = 1'b0;
  endtask

  // one clock: drive inputs, advance the model at the edge, sample 1ns later
  task automatic tick(input logic wr, input logic [15:0] a, input logic [15:0] wd,
                      input logic v, input logic [15:0] d);
    write_io = wr; io_addr = a; io_wdata = wd; flash_valid = v; flash_data = d;
    @(posedge clock);
    if (m_mode == 1) begin
      if (v) begin
        m_mem[m_wr] = d;
        m_wr = (m_wr + 1) % 256;
        m_count++;
      end
      if (wr && a == A_ABORT) begin
        m_mode = 0;
        m_aborted = 1'b1;
      end else if (v && m_count == m_len) begin
        m_mode = 2;
      end
    end else if (m_mode == 0) begin
      if (wr && a == A_START) begin
        m_len = int'(wd[7:0]) + 1;
        m_count = 0; m_wr = 0; m_aborted = 1'b0; m_mode = 1;
      end
    end else if (wr && a == A_ACK) begin
      m_mode = 0;
    end
    #1;
    write_io = 1'b0; flash_valid = 1'b0;
  endtask

  task automatic test_reset();
    #3 reset = 1'b0;
    #1;
    model_reset();
    n_total++;
    if ({get_data, busy, irq, status} !== 19'h0)
      $display("FAIL reset_initial got %h exp %h", {get_data, busy, irq, status}, 19'h0);
    else n_pass++;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
    tick(1'b1, A_START, 16'd19, 1'b0, '0);
    for (int i = 0; i < 5; i++) tick(1'b0, '0, '0, 1'b1, 16'($urandom));
    n_total++;
    if ({get_data, busy, irq, status} !== m_outs())
      $display("FAIL reset_prefetch got %h exp %h", {get_data, busy, irq, status}, m_outs());
    else n_pass++;
    #2 reset = 1'b0;
    #1;
    model_reset();
    n_total++;
    if ({get_data, busy, irq, status} !== 19'h0)
      $display("FAIL reset_midfetch got %h exp %h", {get_data, busy, irq, status}, 19'h0);
    else n_pass++;
    @(negedge clock); reset = 1'b1;
    @(posedge clock); #1;
  endtask

  task automatic test_basic();
    tick(1'b1, A_START, 16'd3, 1'b0, '0);
    n_total++;
    if (get_data !== 1'b1 || busy !== 1'b1)
      $display("FAIL basic_start got gd=%b busy=%b exp 1 1", get_data, busy);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      tick(1'b0, '0, '0, 1'b1, 16'hA000 + 16'(i));
      n_total++;
      if ({get_data, busy, irq, status} !== m_outs())
        $display("FAIL basic_word%0d got %h exp %h", i, {get_data, busy, irq, status}, m_outs());
      else n_pass++;
    end
    n_total++;
    if (status !== 16'h4004 || irq !== 1'b1)
      $display("FAIL basic_done got status=%h irq=%b exp 4004 1", status, irq);
    else n_pass++;
    tick(1'b0, '0, '0, 1'b1, 16'hDEAD);
    n_total++;
    if (status !== 16'h4004)
      $display("FAIL basic_no_extra got %h exp 4004", status);
    else n_pass++;
    for (int i = 0; i < 4; i++) begin
      rd_addr = 8'(i);
      tick(1'b0, '0, '0, 1'b0, '0);
      n_total++;
      if (rd_data !== 16'hA000 + 16'(i))
        $display("FAIL basic_read%0d got %h exp %h", i, rd_data, 16'hA000 + 16'(i));
      else n_pass++;
    end
    tick(1'b1, A_ACK, '0, 1'b0, '0);
  endtask

  task automatic test_full_depth();
    int cyc;
    tick(1'b1, A_START, 16'h00FF, 1'b0, '0);
    cyc = 0;
    while (m_mode == 1 && cyc < 1000) begin
      tick(1'b0, '0, '0, 1'(cyc % 2 == 0), 16'($urandom));
      n_total++;
      if ({get_data, busy, irq, status} !== m_outs())
        $display("FAIL full_cycle%0d got %h exp %h", cyc, {get_data, busy, irq, status}, m_outs());
      else n_pass++;
      cyc++;
    end
    n_total++;
    if (status !== 16'h4100 || busy !== 1'b0)
      $display("FAIL full_done got status=%h busy=%b exp 4100 0", status, busy);
    else n_pass++;
    for (int i = 0; i < 8; i++) begin
      rd_addr = 8'($urandom_range(0, 255));
      tick(1'b0, '0, '0, 1'b0, '0);
      n_total++;
      if (rd_data !== m_mem[rd_addr])
        $display("FAIL full_read[%0d] got %h exp %h", rd_addr, rd_data, m_mem[rd_addr]);
      else n_pass++;
    end
    tick(1'b1, A_ACK, '0, 1'b0, '0);
  endtask

  task automatic test_abort();
    tick(1'b1, A_START, 16'd49, 1'b0, '0);
    for (int i = 0; i < 10; i++) tick(1'b0, '0, '0, 1'b1, 16'($urandom));
    tick(1'b1, A_ABORT, '0, 1'b1, 16'hBEEF);
    n_total++;
    if ({get_data, busy, irq, status} !== {3'b000, 16'h800B})
      $display("FAIL abort_state got %h exp %h", {get_data, busy, irq, status}, {3'b000, 16'h800B});
    else n_pass++;
    rd_addr = 8'd10;
    tick(1'b1, A_ABORT, '0, 1'b0, '0);
    n_total++;
    if (rd_data !== 16'hBEEF || status !== 16'h800B)
      $display("FAIL abort_last_word got rd=%h st=%h exp BEEF 800B", rd_data, status);
    else n_pass++;
    tick(1'b1, A_ACK, '0, 1'b1, 16'h1234);
    tick(1'b1, 16'h5003, '0, 1'b0, '0);
    n_total++;
    if (status !== 16'h800B || irq !== 1'b0)
      $display("FAIL abort_idle_writes got st=%h irq=%b exp 800B 0", status, irq);
    else n_pass++;
    tick(1'b1, A_START, 16'd1, 1'b0, '0);
    n_total++;
    if (status !== 16'h2000)
      $display("FAIL abort_restart got %h exp 2000", status);
    else n_pass++;
    tick(1'b0, '0, '0, 1'b1, 16'($urandom));
    tick(1'b0, '0, '0, 1'b1, 16'($urandom));
    tick(1'b1, A_ACK, '0, 1'b0, '0);
  endtask

  task automatic test_ignored();
    tick(1'b1, A_START, 16'd7, 1'b0, '0);
    for (int i = 0; i < 3; i++) tick(1'b0, '0, '0, 1'b1, 16'($urandom));
    tick(1'b1, A_START, 16'd0, 1'b1, 16'($urandom));
    n_total++;
    if ({get_data, busy, irq, status} !== m_outs() || status !== 16'h2004)
      $display("FAIL ign_start_fetch got %h exp %h", {get_data, busy, irq, status}, m_outs());
    else n_pass++;
    for (int i = 0; i < 4; i++) tick(1'b0, '0, '0, 1'b1, 16'($urandom));
    n_total++;
    if (status !== 16'h4008)
      $display("FAIL ign_done got %h exp 4008", status);
    else n_pass++;
    tick(1'b1, A_START, 16'd5, 1'b1, 16'($urandom));
    tick(1'b1, A_ABORT, '0, 1'b1, 16'($urandom));
    n_total++;
    if ({get_data, busy, irq, status} !== {3'b001, 16'h4008})
      $display("FAIL ign_start_done got %h exp %h", {get_data, busy, irq, status}, {3'b001, 16'h4008});
    else n_pass++;
  endtask

  task automatic test_ack_restart();
    tick(1'b1, A_ACK, '0, 1'b0, '0);
    n_total++;
    if (irq !== 1'b0 || status !== 16'h0008)
      $display("FAIL ack_drop got irq=%b st=%h exp 0 0008", irq, status);
    else n_pass++;
    tick(1'b1, A_START, 16'd2, 1'b0, '0);
    n_total++;
    if ({get_data, busy, irq, status} !== {3'b110, 16'h2000})
      $display("FAIL ack_restart got %h exp %h", {get_data, busy, irq, status}, {3'b110, 16'h2000});
    else n_pass++;
    for (int i = 0; i < 3; i++) tick(1'b0, '0, '0, 1'b1, 16'($urandom));
    tick(1'b1, A_ACK, '0, 1'b0, '0);
  endtask

  task automatic test_random();
    int len, cyc;
    logic ab, v;
    for (int t = 0; t < 6; t++) begin
      len = $urandom_range(1, 40);
      tick(1'b1, A_START, 16'(len - 1), 1'b0, '0);
      cyc = 0;
      while (m_mode == 1 && cyc < 400) begin
        v  = 1'($urandom_range(0, 9) < 7);
        ab = 1'((t == 3) && (m_count >= len / 2) && ($urandom_range(0, 3) == 0));
        tick(ab, A_ABORT, '0, v, 16'($urandom));
        n_total++;
        if ({get_data, busy, irq, status} !== m_outs())
          $display("FAIL rand%0d_cycle%0d got %h exp %h", t, cyc, {get_data, busy, irq, status}, m_outs());
        else n_pass++;
        cyc++;
      end
      n_total++;
      if (busy !== 1'b0)
        $display("FAIL rand%0d_timeout got busy=%b exp 0", t, busy);
      else n_pass++;
      for (int i = 0; i < 3 && m_count > 0; i++) begin
        rd_addr = 8'($urandom_range(0, m_count - 1));
        tick(1'b0, '0, '0, 1'b1, 16'($urandom));
        n_total++;
        if (rd_data !== m_mem[rd_addr])
          $display("FAIL rand%0d_read[%0d] got %h exp %h", t, rd_addr, rd_data, m_mem[rd_addr]);
        else n_pass++;
      end
      tick(1'b1, A_ACK, '0, 1'b0, '0);
      n_total++;
      if ({get_data, busy, irq, status} !== m_outs())
        $display("FAIL rand%0d_ack got %h exp %h", t, {get_data, busy, irq, status}, m_outs());
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full_depth();
    test_abort();
    test_ignored();
    test_ack_restart();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
